// File: rtl/zbt_arbiter_if.sv
// Bus bundle for the ZBT arbiter: NTSC write strobe, VGA and tracker read
// ports, and the single-ported ZBT SRAM side.
interface zbt_arbiter_if;
  logic        ntsc_we;
  logic [18:0] ntsc_addr;
  logic [35:0] ntsc_data;

  logic        vga_req;
  logic [18:0] vga_addr;
  logic        vga_ack;
  logic        vga_valid;
  logic [35:0] vga_data;

  logic        trk_req;
  logic [18:0] trk_addr;
  logic        trk_ack;
  logic        trk_valid;
  logic [35:0] trk_data;

  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic [35:0] zbt_rdata;

  logic        ntsc_overflow;

  // Arbiter side
  modport slave (
    input  ntsc_we, ntsc_addr, ntsc_data,
    input  vga_req, vga_addr,
    input  trk_req, trk_addr,
    input  zbt_rdata,
    output vga_ack, vga_valid, vga_data,
    output trk_ack, trk_valid, trk_data,
    output zbt_addr, zbt_we, zbt_wdata,
    output ntsc_overflow
  );

  // Requester / memory side
  modport master (
    output ntsc_we, ntsc_addr, ntsc_data,
    output vga_req, vga_addr,
    output trk_req, trk_addr,
    output zbt_rdata,
    input  vga_ack, vga_valid, vga_data,
    input  trk_ack, trk_valid, trk_data,
    input  zbt_addr, zbt_we, zbt_wdata,
    input  ntsc_overflow
  );
endinterface

// File: rtl/zbt_arbiter.sv
// ZBT SRAM arbiter: one access per cycle shared between a buffered NTSC
// write stream and two read ports (VGA display, tracker). VGA has priority,
// but a pending NTSC write is forced through after STARVE_MAX lost cycles.
// Read returns are steered by a tag pipeline matched to the SRAM latency.
module zbt_arbiter #(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input logic          clk,
  input logic          reset_n,
  zbt_arbiter_if.slave bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_TRK  = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_NTSC = 2'd2,
    GNT_TRK  = 2'd3
  } gnt_e;

  // NTSC write FIFO, entry = {addr, data}
  logic [54:0]   r_fifo_mem [0:1];
  logic          r_fifo_wptr;
  logic          r_fifo_rptr;
  logic [1:0]    r_fifo_cnt;

  logic [SW-1:0] r_starve_cnt;
  logic          r_overflow;

  logic [18:0]   r_zbt_addr;
  logic          r_zbt_we;
  logic [35:0]   r_zbt_wdata;

  // Stage 0 is aligned with zbt_addr; stage RD_LAT sees zbt_rdata
  logic [1:0]    r_tag   [0:RD_LAT];
  logic [35:0]   r_wpipe [0:RD_LAT-1];
  logic          r_wvld  [0:RD_LAT-1];

  logic          r_vga_valid;
  logic          r_trk_valid;
  logic [35:0]   r_vga_data;
  logic [35:0]   r_trk_data;

  gnt_e          w_gnt;
  logic          w_fifo_ne;
  logic          w_fifo_full;
  logic          w_push;
  logic          w_pop;
  logic [54:0]   w_head;
  logic [SW-1:0] w_starve_nxt;
  logic [1:0]    w_tag_in;

  assign w_fifo_ne   = (r_fifo_cnt != 2'd0);
  assign w_fifo_full = (r_fifo_cnt == 2'd2);
  assign w_head      = r_fifo_mem[r_fifo_rptr];
  assign w_pop       = (w_gnt == GNT_NTSC);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push      = bus.ntsc_we & (~w_fifo_full | w_pop);

  assign bus.zbt_addr      = r_zbt_addr;
  assign bus.zbt_we        = r_zbt_we;
  assign bus.zbt_wdata     = r_zbt_wdata;
  assign bus.vga_valid     = r_vga_valid;
  assign bus.vga_data      = r_vga_data;
  assign bus.trk_valid     = r_trk_valid;
  assign bus.trk_data      = r_trk_data;
  assign bus.ntsc_overflow = r_overflow;

  // Pick this cycle's single winner: starved NTSC, then VGA, NTSC, tracker
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_fifo_ne && (r_starve_cnt == STARVE_LIM)) begin
      w_gnt = GNT_NTSC;
    end else if (bus.vga_req) begin
      w_gnt = GNT_VGA;
    end else if (w_fifo_ne) begin
      w_gnt = GNT_NTSC;
    end else if (bus.trk_req) begin
      w_gnt = GNT_TRK;
    end else begin
      w_gnt = GNT_NONE;
    end
  end

  // Count cycles a waiting NTSC write loses to VGA, saturating at the limit
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!w_fifo_ne || (w_gnt == GNT_NTSC)) begin
      w_starve_nxt = '0;
    end else if ((w_gnt == GNT_VGA) && (r_starve_cnt != STARVE_LIM)) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  // Same-cycle grant pulses, forced low while reset is held
  always_comb begin
    bus.vga_ack = 1'b0;
    bus.trk_ack = 1'b0;
    if (reset_n) begin
      bus.vga_ack = (w_gnt == GNT_VGA);
      bus.trk_ack = (w_gnt == GNT_TRK);
    end else begin
      bus.vga_ack = 1'b0;
      bus.trk_ack = 1'b0;
    end
  end

  // Tag recording which read port owns the access being issued
  always_comb begin
    case (w_gnt)
      GNT_VGA: w_tag_in = TAG_VGA;
      GNT_TRK: w_tag_in = TAG_TRK;
      default: w_tag_in = TAG_NONE;
    endcase
  end

  // Two-entry NTSC write FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
      r_fifo_wptr   <= 1'b0;
      r_fifo_rptr   <= 1'b0;
      r_fifo_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_fifo_wptr] <= {bus.ntsc_addr, bus.ntsc_data};
        r_fifo_wptr             <= ~r_fifo_wptr;
      end
      if (w_pop) begin
        r_fifo_rptr <= ~r_fifo_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Starvation counter and sticky overflow flag for dropped NTSC writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (bus.ntsc_we && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Register the winning address; idle cycles hold the address, drop we
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zbt_addr <= '0;
      r_zbt_we   <= 1'b0;
    end else begin
      case (w_gnt)
        GNT_VGA: begin
          r_zbt_addr <= bus.vga_addr;
          r_zbt_we   <= 1'b0;
        end
        GNT_TRK: begin
          r_zbt_addr <= bus.trk_addr;
          r_zbt_we   <= 1'b0;
        end
        GNT_NTSC: begin
          r_zbt_addr <= w_head[54:36];
          r_zbt_we   <= 1'b1;
        end
        default: begin
          r_zbt_addr <= r_zbt_addr;
          r_zbt_we   <= 1'b0;
        end
      endcase
    end
  end

  // Read-owner tag pipeline, cleared on reset so in-flight reads vanish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        r_tag[i] <= TAG_NONE;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Write-data pipeline: data reaches zbt_wdata RD_LAT cycles after zbt_we
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_wpipe[i] <= '0;
        r_wvld[i]  <= 1'b0;
      end
      r_zbt_wdata <= '0;
    end else begin
      r_wpipe[0] <= w_head[35:0];
      r_wvld[0]  <= w_pop;
      for (int i = 1; i < RD_LAT; i++) begin
        r_wpipe[i] <= r_wpipe[i-1];
        r_wvld[i]  <= r_wvld[i-1];
      end
      if (r_wvld[RD_LAT-1]) begin
        r_zbt_wdata <= r_wpipe[RD_LAT-1];
      end
    end
  end

  // Steer returning read data to the port named by the exiting tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vga_valid <= 1'b0;
      r_trk_valid <= 1'b0;
      r_vga_data  <= '0;
      r_trk_data  <= '0;
    end else begin
      r_vga_valid <= (r_tag[RD_LAT] == TAG_VGA);
      r_trk_valid <= (r_tag[RD_LAT] == TAG_TRK);
      if (r_tag[RD_LAT] == TAG_VGA) begin
        r_vga_data <= bus.zbt_rdata;
      end
      if (r_tag[RD_LAT] == TAG_TRK) begin
        r_trk_data <= bus.zbt_rdata;
      end
    end
  end

endmodule

// File: tb/tb_zbt_arbiter.sv
// Bench for zbt_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based model that schedules expected events by cycle index.
module tb_zbt_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;
  localparam int NMAX       = 2048;

  typedef enum int {G_NONE, G_VGA, G_NTSC, G_TRK} g_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  zbt_arbiter_if bus ();

  zbt_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;   // rising edges seen

  // reference model state
  logic [18:0] mq_addr [$];
  logic [35:0] mq_data [$];
  int          m_starve;
  logic        m_ovf;
  logic        m_we;
  logic [18:0] m_addr;
  logic [35:0] m_vdata, m_tdata, m_wdata;
  logic        s_vv [NMAX];
  logic        s_tv [NMAX];
  logic        s_wv [NMAX];
  logic [35:0] s_vd [NMAX];
  logic [35:0] s_td [NMAX];
  logic [35:0] s_wd [NMAX];
  logic [18:0] zhist [$];
  logic        obs_vack, obs_tack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic g_t model_gnt(input logic vreq, input logic treq);
    if (mq_addr.size() != 0 && m_starve == STARVE_MAX) return G_NTSC;
    if (vreq) return G_VGA;
    if (mq_addr.size() != 0) return G_NTSC;
    if (treq) return G_TRK;
    return G_NONE;
  endfunction

  task automatic model_reset();
    mq_addr.delete();
    mq_data.delete();
    m_starve = 0;
    m_ovf    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_vdata  = '0;
    m_tdata  = '0;
    m_wdata  = '0;
    for (int i = 0; i < NMAX; i++) begin
      s_vv[i] = 1'b0; s_tv[i] = 1'b0; s_wv[i] = 1'b0;
      s_vd[i] = '0;   s_td[i] = '0;   s_wd[i] = '0;
    end
  endtask

  // Apply the effect of a grant taken at edge n
  task automatic model_edge(input g_t g);
    bit was_empty;
    was_empty = (mq_addr.size() == 0);
    m_we = 1'b0;
    case (g)
      G_VGA: begin
        m_addr = bus.vga_addr;
        s_vv[n+RD_LAT+1] = 1'b1;
        s_vd[n+RD_LAT+1] = {17'd0, bus.vga_addr};
      end
      G_TRK: begin
        m_addr = bus.trk_addr;
        s_tv[n+RD_LAT+1] = 1'b1;
        s_td[n+RD_LAT+1] = {17'd0, bus.trk_addr};
      end
      G_NTSC: begin
        m_addr = mq_addr.pop_front();
        m_we   = 1'b1;
        s_wv[n+RD_LAT] = 1'b1;
        s_wd[n+RD_LAT] = mq_data.pop_front();
      end
      default: ;
    endcase
    if (bus.ntsc_we) begin
      if (mq_addr.size() < 2) begin
        mq_addr.push_back(bus.ntsc_addr);
        mq_data.push_back(bus.ntsc_data);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (g == G_NTSC || was_empty) m_starve = 0;
    else if (g == G_VGA && m_starve < STARVE_MAX) m_starve++;
  endtask

  // SRAM model: data word equals the address presented RD_LAT cycles ago
  task automatic zbt_tick();
    logic [18:0] dropped;
    zhist.push_front(bus.zbt_addr);
    if (zhist.size() > RD_LAT + 1) dropped = zhist.pop_back();
    bus.zbt_rdata = (zhist.size() == RD_LAT + 1) ? {17'd0, zhist[RD_LAT]} : 36'd0;
  endtask

  task automatic check_regs();
    if (s_vv[n]) m_vdata = s_vd[n];
    if (s_tv[n]) m_tdata = s_td[n];
    if (s_wv[n]) m_wdata = s_wd[n];
    chk("zbt_we",    bus.zbt_we,    m_we);
    chk("zbt_addr",  bus.zbt_addr,  m_addr);
    chk("overflow",  bus.ntsc_overflow, m_ovf);
    chk("vga_valid", bus.vga_valid, s_vv[n]);
    chk("vga_data",  bus.vga_data,  m_vdata);
    chk("trk_valid", bus.trk_valid, s_tv[n]);
    chk("trk_data",  bus.trk_data,  m_tdata);
    chk("zbt_wdata", bus.zbt_wdata, m_wdata);
    chk("both_valid", bus.vga_valid & bus.trk_valid, 1'b0);
  endtask

  task automatic check_zero();
    chk("rst_vga_ack", bus.vga_ack, 1'b0);
    chk("rst_trk_ack", bus.trk_ack, 1'b0);
    chk("rst_vga_valid", bus.vga_valid, 1'b0);
    chk("rst_trk_valid", bus.trk_valid, 1'b0);
    chk("rst_vga_data", bus.vga_data, 36'd0);
    chk("rst_trk_data", bus.trk_data, 36'd0);
    chk("rst_zbt_addr", bus.zbt_addr, 19'd0);
    chk("rst_zbt_we", bus.zbt_we, 1'b0);
    chk("rst_zbt_wdata", bus.zbt_wdata, 36'd0);
    chk("rst_overflow", bus.ntsc_overflow, 1'b0);
  endtask

  // One clock: check acks mid-cycle, advance model at the edge, check regs
  task automatic step();
    g_t g;
    @(negedge clk);
    g = model_gnt(bus.vga_req, bus.trk_req);
    obs_vack = bus.vga_ack;
    obs_tack = bus.trk_ack;
    chk("vga_ack", bus.vga_ack, (g == G_VGA));
    chk("trk_ack", bus.trk_ack, (g == G_TRK));
    @(posedge clk);
    n++;
    model_edge(g);
    #1;
    zbt_tick();
    check_regs();
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      n++;
      #1;
      zbt_tick();
      check_zero();
    end
    bus.vga_req = 1'b0;
    bus.trk_req = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r64;
    int          vcnt;
    bit          done;
    logic [18:0] got [$];

    reset_n = 1'b1;
    bus.ntsc_we = 1'b0; bus.ntsc_addr = '0; bus.ntsc_data = '0;
    bus.vga_req = 1'b0; bus.vga_addr = '0;
    bus.trk_req = 1'b0; bus.trk_addr = '0;
    bus.zbt_rdata = '0;
    obs_vack = 1'b0; obs_tack = 1'b0;
    #1;
    do_reset(3);

    // single VGA read returns its address RD_LAT+1 edges after the grant
    bus.vga_req = 1'b1; bus.vga_addr = 19'h00010;
    step();
    chk("t34_ack", obs_vack, 1'b1);
    bus.vga_req = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      step();
      if (k <= RD_LAT) chk("t34_early_valid", bus.vga_valid, 1'b0);
    end
    chk("t34_valid", bus.vga_valid, 1'b1);
    chk("t34_data", bus.vga_data, 36'h000000010);

    // held VGA starves one NTSC write for exactly STARVE_MAX grants
    bus.vga_req = 1'b1; bus.vga_addr = 19'h00100;
    bus.ntsc_we = 1'b1; bus.ntsc_addr = 19'h5A5A5; bus.ntsc_data = 36'hABCDE0123;
    step();
    bus.ntsc_we = 1'b0;
    if (obs_vack) bus.vga_addr = bus.vga_addr + 19'd1;
    vcnt = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      if (obs_vack) begin
        vcnt++;
        bus.vga_addr = bus.vga_addr + 19'd1;
      end else begin
        done = 1'b1;
      end
    end
    chk("t35_vga_grants", vcnt, STARVE_MAX);
    chk("t35_we", bus.zbt_we, 1'b1);
    chk("t35_addr", bus.zbt_addr, 19'h5A5A5);
    for (int k = 0; k < RD_LAT; k++) begin
      step();
      chk("t35_vga_resume", obs_vack, 1'b1);
      bus.vga_addr = bus.vga_addr + 19'd1;
    end
    chk("t38_wdata", bus.zbt_wdata, 36'hABCDE0123);
    chk("t35_no_ovf", bus.ntsc_overflow, 1'b0);
    bus.vga_req = 1'b0;
    repeat (RD_LAT + 3) step();

    // VGA beats tracker; tracker granted once VGA drops
    bus.vga_req = 1'b1; bus.vga_addr = 19'h00222;
    bus.trk_req = 1'b1; bus.trk_addr = 19'h70001;
    step();
    chk("t37_vga_first", obs_vack, 1'b1);
    chk("t37_trk_wait", obs_tack, 1'b0);
    bus.vga_req = 1'b0;
    step();
    chk("t37_trk_next", obs_tack, 1'b1);
    bus.trk_req = 1'b0;
    repeat (RD_LAT + 2) step();
    chk("t37_vga_data", bus.vga_data, 36'h000000222);
    chk("t37_trk_data", bus.trk_data, 36'h000070001);

    // three back-to-back NTSC writes while starved: third dropped
    bus.vga_req = 1'b1; bus.vga_addr = 19'h01000;
    bus.ntsc_we = 1'b1;
    bus.ntsc_addr = 19'h11111; bus.ntsc_data = 36'h111111111;
    step(); if (obs_vack) bus.vga_addr = bus.vga_addr + 19'd1;
    bus.ntsc_addr = 19'h22222; bus.ntsc_data = 36'h222222222;
    step(); if (obs_vack) bus.vga_addr = bus.vga_addr + 19'd1;
    bus.ntsc_addr = 19'h33333; bus.ntsc_data = 36'h333333333;
    step(); if (obs_vack) bus.vga_addr = bus.vga_addr + 19'd1;
    bus.ntsc_we = 1'b0;
    chk("t36_ovf_set", bus.ntsc_overflow, 1'b1);
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.zbt_we) got.push_back(bus.zbt_addr);
      if (obs_vack) bus.vga_addr = bus.vga_addr + 19'd1;
    end
    bus.vga_req = 1'b0;
    repeat (RD_LAT + 3) step();
    chk("t36_writes", got.size(), 2);
    chk("t36_wr0", (got.size() > 0) ? got[0] : 19'h7FFFF, 19'h11111);
    chk("t36_wr1", (got.size() > 1) ? got[1] : 19'h7FFFF, 19'h22222);
    chk("t36_ovf_sticky", bus.ntsc_overflow, 1'b1);

    // randomized traffic on all three ports
    for (int c = 0; c < 400; c++) begin
      if (!bus.vga_req || obs_vack) begin
        bus.vga_req  = ($urandom_range(0, 99) < 55);
        bus.vga_addr = 19'($urandom());
      end
      if (!bus.trk_req || obs_tack) begin
        bus.trk_req  = ($urandom_range(0, 99) < 45);
        bus.trk_addr = 19'($urandom());
      end
      bus.ntsc_we   = ($urandom_range(0, 99) < 20);
      bus.ntsc_addr = 19'($urandom());
      r64 = {$urandom(), $urandom()};
      bus.ntsc_data = r64[35:0];
      step();
    end
    bus.vga_req = 1'b0; bus.trk_req = 1'b0; bus.ntsc_we = 1'b0;
    repeat (RD_LAT + 6) step();

    // reset while a VGA read is in flight: its valid pulse must not appear
    bus.vga_req = 1'b1; bus.vga_addr = 19'h00333;
    step();
    chk("t39_ack", obs_vack, 1'b1);
    step();
    do_reset(1);
    vcnt = 0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      step();
      if (bus.vga_valid === 1'b1) vcnt++;
    end
    chk("t39_no_valid", vcnt, 0);
    bus.vga_req = 1'b1; bus.vga_addr = 19'h00444;
    step();
    chk("t39_resume_ack", obs_vack, 1'b1);
    bus.vga_req = 1'b0;
    repeat (RD_LAT + 1) step();
    chk("t39_resume_valid", bus.vga_valid, 1'b1);
    chk("t39_resume_data", bus.vga_data, 36'h000000444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
